// File: rtl/commit_trace_fifo_if.sv
// Output stream of the commit trace FIFO: one tagged event per accepted handshake.
//   out_valid  head entry available (driven by the FIFO)
//   out_ready  consumer accepts the head this cycle (driven by the consumer)
//   out_kind   0 = register write, 1 = memory write
//   out_pc     PC of the committing instruction
//   out_addr   register index (zero-extended) or byte address
//   out_data   value written
//   out_ts     capture-cycle timestamp
// master: FIFO side; slave: consumer side.
interface commit_trace_fifo_if #(
    parameter int unsigned TS_WIDTH = 16
);
    logic                out_valid;
    logic                out_ready;
    logic                out_kind;
    logic [31:0]         out_pc;
    logic [31:0]         out_addr;
    logic [31:0]         out_data;
    logic [TS_WIDTH-1:0] out_ts;

    modport master (
        output out_valid, out_kind, out_pc, out_addr, out_data, out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_kind, out_pc, out_addr, out_data, out_ts,
        output out_ready
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: records architectural register and memory writes as timestamped events
// and drains them in order over a valid/ready stream.
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   enable                   capture enable (timestamp keeps running when low)
//   pc                       PC of the committing instruction
//   RegWrite/RegAddr/RegData register-write commit
//   MemWrite/MemAddr/MemData memory-write commit
//   out_if                   show-ahead event stream (master side)
//   count                    entries currently held
//   overflow                 sticky: at least one event was dropped
//   drop_count               saturating count of dropped events
module commit_trace_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned DROP_WIDTH = 8,
    parameter bit          FILTER_R0  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [31:0]             pc,
    input  logic                    RegWrite,
    input  logic [4:0]              RegAddr,
    input  logic [31:0]             RegData,
    input  logic                    MemWrite,
    input  logic [31:0]             MemAddr,
    input  logic [31:0]             MemData,
    commit_trace_fifo_if.master     out_if,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [DROP_WIDTH-1:0]   drop_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic                kind;
        logic [31:0]         pc;
        logic [31:0]         addr;
        logic [31:0]         data;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic [DROP_WIDTH:0]   drop_sum;

    logic       out_valid;
    logic       pop;
    logic       reg_ev;
    logic       mem_ev;
    logic [1:0] n_cand;
    logic [1:0] n_push;
    logic [1:0] n_drop;
    logic [CW-1:0] space;
    entry_t     reg_ent;
    entry_t     mem_ent;
    entry_t     first_ent;
    entry_t     head;

    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_valid & out_if.out_ready;
        // Free slots this cycle include the one a simultaneous pop releases.
        space     = CW'(DEPTH) - count_q + CW'(pop);

        reg_ev = enable & RegWrite & ~(FILTER_R0 & (RegAddr == 5'd0));
        mem_ev = enable & MemWrite;
        n_cand = {1'b0, reg_ev} + {1'b0, mem_ev};
        // Grant in order; only reachable short case is space of 0 or 1.
        n_push = (space >= CW'(n_cand)) ? n_cand : space[1:0];
        n_drop = n_cand - n_push;

        reg_ent   = '{kind: 1'b0, pc: pc, addr: {27'b0, RegAddr}, data: RegData, ts: ts_q};
        mem_ent   = '{kind: 1'b1, pc: pc, addr: MemAddr, data: MemData, ts: ts_q};
        // The reg event always takes the first slot when present.
        first_ent = reg_ev ? reg_ent : mem_ent;

        wr_ptr_nx = wr_ptr_q + PW'(1);
        wr_ptr_d  = wr_ptr_q + PW'(n_push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(n_push) - CW'(pop);

        drop_sum   = {1'b0, drop_q} + (DROP_WIDTH + 1)'(n_drop);
        drop_d     = drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
        overflow_d = overflow_q | (n_drop != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ts_q       <= ts_q + TS_WIDTH'(1);
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (n_push != 2'd0) begin
                mem_q[wr_ptr_q] <= first_ent;
            end
            if (n_push == 2'd2) begin
                mem_q[wr_ptr_nx] <= mem_ent;
            end
        end
    end

    always_comb begin
        head             = mem_q[rd_ptr_q];
        out_if.out_valid = out_valid;
        out_if.out_kind  = head.kind;
        out_if.out_pc    = head.pc;
        out_if.out_addr  = head.addr;
        out_if.out_data  = head.data;
        out_if.out_ts    = head.ts;
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] pc;
    logic        RegWrite;
    logic [4:0]  RegAddr;
    logic [31:0] RegData;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemData;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    commit_trace_fifo_if #(.TS_WIDTH(16)) tr_if ();

    commit_trace_fifo #(
        .DEPTH(DEPTH), .TS_WIDTH(16), .DROP_WIDTH(8), .FILTER_R0(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pc(pc),
        .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData),
        .out_if(tr_if.master),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of events plus scalar status.
    typedef struct {
        bit          kind;
        bit [31:0]   pc;
        bit [31:0]   addr;
        bit [31:0]   data;
        int          ts;
    } ev_t;

    ev_t q_m[$];
    int  ts_m;
    bit  ovf_m;
    int  drop_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        ts_m   = 0;
        ovf_m  = 0;
        drop_m = 0;
    endtask

    task automatic model_edge();
        int   space;
        int   drops;
        bit   pop;
        ev_t  e;
        if (reset) begin
            model_reset();
            return;
        end
        pop   = (q_m.size() > 0) && tr_if.out_ready;
        space = DEPTH - q_m.size() + (pop ? 1 : 0);
        drops = 0;
        if (pop) void'(q_m.pop_front());
        if (enable && RegWrite && RegAddr != 0) begin
            e = '{kind: 1'b0, pc: pc, addr: {27'b0, RegAddr}, data: RegData, ts: ts_m};
            if (space > 0) begin q_m.push_back(e); space--; end
            else drops++;
        end
        if (enable && MemWrite) begin
            e = '{kind: 1'b1, pc: pc, addr: MemAddr, data: MemData, ts: ts_m};
            if (space > 0) begin q_m.push_back(e); space--; end
            else drops++;
        end
        if (drops > 0) ovf_m = 1;
        drop_m = (drop_m + drops > 255) ? 255 : drop_m + drops;
        ts_m   = (ts_m + 1) % 65536;
    endtask

    task automatic compare_all();
        check("count", count, q_m.size());
        check("out_valid", tr_if.out_valid, q_m.size() != 0);
        check("overflow", overflow, ovf_m);
        check("drop_count", drop_count, drop_m);
        if (q_m.size() != 0) begin
            check("out_kind", tr_if.out_kind, q_m[0].kind);
            check("out_pc", tr_if.out_pc, q_m[0].pc);
            check("out_addr", tr_if.out_addr, q_m[0].addr);
            check("out_data", tr_if.out_data, q_m[0].data);
            check("out_ts", tr_if.out_ts, q_m[0].ts);
        end
    endtask

    // Check state at the falling edge, advance the model, cross the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable   = 1'b1;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        RegAddr  = 5'd0;
        RegData  = '0;
        MemAddr  = '0;
        MemData  = '0;
        pc       = '0;
    endtask

    task automatic reg_ev(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        RegWrite = 1'b1; RegAddr = a; RegData = d; pc = p;
    endtask

    task automatic mem_ev(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; MemAddr = a; MemData = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tr_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        // 1: single reg event at ts=3
        repeat (3) cycle();
        reg_ev(5'd8, 32'h1234, 32'h3000);
        cycle();
        idle();
        check("t1_valid", tr_if.out_valid, 1);
        check("t1_kind", tr_if.out_kind, 0);
        check("t1_addr", tr_if.out_addr, 8);
        check("t1_data", tr_if.out_data, 32'h1234);
        check("t1_pc", tr_if.out_pc, 32'h3000);
        check("t1_ts", tr_if.out_ts, 3);

        // 2: dual event while popping the first one
        tr_if.out_ready = 1'b1;
        reg_ev(5'd9, 32'h55, 32'h3004);
        mem_ev(32'h10, 32'hABCD);
        cycle();
        idle();
        tr_if.out_ready = 1'b0;
        check("t2_count", count, 2);
        check("t2_kind0", tr_if.out_kind, 0);
        tr_if.out_ready = 1'b1;
        cycle();
        tr_if.out_ready = 1'b0;
        check("t2_kind1", tr_if.out_kind, 1);
        check("t2_addr1", tr_if.out_addr, 32'h10);
        check("t2_data1", tr_if.out_data, 32'hABCD);
        check("t2_ts_same", tr_if.out_ts, 4);

        // 3: $0 filtered; disabled capture ignored
        reg_ev(5'd0, 32'hDEAD, 32'h3008);
        cycle();
        check("t3_r0_count", count, 1);
        enable = 1'b0;
        reg_ev(5'd5, 32'hBEEF, 32'h300C);
        cycle();
        idle();
        check("t3_dis_count", count, 1);
        tr_if.out_ready = 1'b1;
        for (int i = 0; i < 4 && count != 0; i++) cycle();
        check("t3_drained", count, 0);
        tr_if.out_ready = 1'b0;

        // 4: fill to 15, then dual events overflow
        for (int i = 0; i < 15; i++) begin
            reg_ev(5'(i + 1), 32'(i * 7), 32'h4000 + 32'(i * 4));
            cycle();
        end
        reg_ev(5'd20, 32'h99, 32'h5000);
        mem_ev(32'h20, 32'h77);
        cycle();
        check("t4_count", count, 16);
        check("t4_ovf", overflow, 1);
        check("t4_drop1", drop_count, 1);
        cycle();
        idle();
        check("t4_drop3", drop_count, 3);

        // 5: full, pop + push together
        tr_if.out_ready = 1'b1;
        reg_ev(5'd3, 32'h333, 32'h6000);
        cycle();
        idle();
        tr_if.out_ready = 1'b0;
        check("t5_count", count, 16);
        check("t5_drop", drop_count, 3);

        // 6: reset with 7 entries held
        tr_if.out_ready = 1'b1;
        repeat (9) cycle();
        tr_if.out_ready = 1'b0;
        check("t6_held", count, 7);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6_count", count, 0);
        check("t6_valid", tr_if.out_valid, 0);
        check("t6_ovf", overflow, 0);
        check("t6_drop", drop_count, 0);
        reg_ev(5'd1, 32'h1, 32'h7000);
        cycle();
        idle();
        check("t6_ts", tr_if.out_ts, 0);

        // Randomized traffic with phases of varying consumer speed
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct  = ((i / 250) % 3 == 0) ? 15 : (((i / 250) % 3 == 1) ? 60 : 95);
            enable   = ($urandom_range(99) < 90);
            RegWrite = ($urandom_range(99) < 60);
            RegAddr  = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
            RegData  = $urandom;
            MemWrite = ($urandom_range(99) < 40);
            MemAddr  = $urandom;
            MemData  = $urandom;
            pc       = $urandom;
            tr_if.out_ready = ($urandom_range(99) < rdy_pct);
            reset    = ($urandom_range(399) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
